// File: rtl/modport_source_driver_if.sv
// Bundle between a data producer and the source driver.
// master: the producer/bench side. slave: the driver block.
// src_out is the source-modport drive of the interface array.
// snk_in is the sink-modport readback of the same wires.
interface modport_source_driver_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    logic [N-1:0]     value;
    logic [N-1:0]     load_en;
    logic [N-1:0]     src_out;
    logic [N-1:0]     snk_in;
    logic             check_en;
    logic [N-1:0]     mismatch;
    logic [CNT_W-1:0] err_count;
    logic             all_ok;

    modport master (
        output value, load_en, snk_in, check_en,
        input  src_out, mismatch, err_count, all_ok
    );

    modport slave (
        input  value, load_en, snk_in, check_en,
        output src_out, mismatch, err_count, all_ok
    );
endinterface

// File: rtl/modport_source_driver.sv
// Source driver for an interface array ifs[N-1:0].
// - Drives the logic_in_intf wire of each slot, either straight from value or
//   through a per-slot load-enabled register.
// - Checks the sink-side readback against what was actually driven.
// - Keeps sticky per-slot mismatch flags and a saturating event counter.

// One slot: drive path, loopback difference and sticky flag.
module modport_source_driver_lane #(
    parameter int REG_OUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic value,
    input  logic load_en,
    input  logic snk,
    input  logic check_en,
    output logic src,
    output logic diff,
    output logic mis
);
    generate
        if (REG_OUT != 0) begin : g_reg
            // Registered drive: reset clears it, load_en updates it, otherwise it holds.
            always_ff @(posedge clk) begin
                if (rst)          src <= 1'b0;
                else if (load_en) src <= value;
            end
        end else begin : g_comb
            // Combinational drive has no state, so rst and load_en do not affect it.
            assign src = value;
        end
    endgenerate

    // Compare the readback against the value actually driven, not against the raw input.
    assign diff = snk ^ src;

    // Sticky flag: set on a checked difference; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)                    mis <= 1'b0;
        else if (check_en && diff)  mis <= 1'b1;
    end

    // load_en has no use when the drive path is combinational.
    logic unused_load;
    assign unused_load = (REG_OUT == 0) ? load_en : 1'b0;
endmodule

module modport_source_driver #(
    parameter int N       = 2,
    parameter int REG_OUT = 0,
    parameter int CNT_W   = 8
) (
    input logic                    clk,
    input logic                    rst,
    modport_source_driver_if.slave bus
);
    localparam int PW = $clog2(N + 1);
    localparam int SW = CNT_W + PW + 1;

    logic [N-1:0]     diff;
    logic [N-1:0]     src;
    logic [N-1:0]     mis;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_nxt;

    genvar j;
    generate
        for (j = 0; j < N; j++) begin : g_lane
            modport_source_driver_lane #(.REG_OUT(REG_OUT)) u_lane (
                .clk      (clk),
                .rst      (rst),
                .value    (bus.value[j]),
                .load_en  (bus.load_en[j]),
                .snk      (bus.snk_in[j]),
                .check_en (bus.check_en),
                .src      (src[j]),
                .diff     (diff[j]),
                .mis      (mis[j])
            );
        end
    endgenerate

    // Count differing slots and add to the running total, clamping at all-ones.
    always_comb begin
        pop = '0;
        for (int k = 0; k < N; k++) pop = pop + PW'(diff[k]);
        sum = SW'(err_q) + SW'(pop);
        if (sum > SW'({CNT_W{1'b1}})) err_nxt = {CNT_W{1'b1}};
        else                          err_nxt = sum[CNT_W-1:0];
    end

    // Error counter: rst wins over check_en; check_en low holds the count.
    always_ff @(posedge clk) begin
        if (rst)               err_q <= '0;
        else if (bus.check_en) err_q <= err_nxt;
    end

    assign bus.src_out   = src;
    assign bus.mismatch  = mis;
    assign bus.err_count = err_q;
    assign bus.all_ok    = ~|mis;
endmodule

// File: tb/tb_modport_source_driver.sv
// Directed bench over three builds: combinational N=2, registered N=2 with
// a 2-bit counter, and combinational N=1. Expected values are queued when
// stimulus is applied and popped when the outputs are sampled.
module tb_modport_source_driver;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    modport_source_driver_if #(.N(2), .CNT_W(8)) if0 ();
    modport_source_driver_if #(.N(2), .CNT_W(2)) if1 ();
    modport_source_driver_if #(.N(1), .CNT_W(8)) if2 ();

    // Loopback selects: sink follows the driven wire, or a forced value.
    logic       lb0, lb1, lb2;
    logic [1:0] frc0, frc1;
    logic       frc2;
    assign if0.snk_in = lb0 ? if0.src_out : frc0;
    assign if1.snk_in = lb1 ? if1.src_out : frc1;
    assign if2.snk_in = lb2 ? if2.src_out : frc2;

    modport_source_driver #(.N(2), .REG_OUT(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    modport_source_driver #(.N(2), .REG_OUT(1), .CNT_W(2)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    modport_source_driver #(.N(1), .REG_OUT(0), .CNT_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic push(input string tag, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val)
            else begin
                miscompares++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        lb0 = 1'b1; lb1 = 1'b1; lb2 = 1'b1;
        frc0 = 2'b00; frc1 = 2'b00; frc2 = 1'b0;
        if0.value = '0; if0.load_en = '0; if0.check_en = 1'b0;
        if1.value = '0; if1.load_en = '0; if1.check_en = 1'b0;
        if2.value = '0; if2.load_en = '0; if2.check_en = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        push("rst_mis0", 0); push("rst_err0", 0); push("rst_ok0", 1);
        push("rst_src1", 0); push("rst_mis1", 0); push("rst_err1", 0);
        #1;
        check(32'(if0.mismatch)); check(32'(if0.err_count)); check(32'(if0.all_ok));
        check(32'(if1.src_out)); check(32'(if1.mismatch)); check(32'(if1.err_count));

        // Combinational drive with loopback: no mismatch after 4 cycles
        if0.value = 2'b01; if0.check_en = 1'b1;
        push("comb_src", 2'b01);
        #1;
        check(32'(if0.src_out));
        push("loop_mis", 0); push("loop_ok", 1); push("loop_err", 0);
        repeat (4) tick();
        check(32'(if0.mismatch)); check(32'(if0.all_ok)); check(32'(if0.err_count));

        // Registered drive: per-slot load enables, then hold
        if1.value = 2'b11; if1.load_en = 2'b01;
        push("reg_ld0", 2'b01);
        tick();
        check(32'(if1.src_out));
        if1.load_en = 2'b10;
        push("reg_ld1", 2'b11);
        tick();
        check(32'(if1.src_out));
        if1.load_en = 2'b00; if1.value = 2'b00;
        push("reg_hold", 2'b11);
        tick();
        check(32'(if1.src_out));

        // Forced readback 10 against driven 01 for one checked cycle
        lb0 = 1'b0; frc0 = 2'b10;
        push("mm_mis", 2'b11); push("mm_err", 2); push("mm_ok", 0);
        tick();
        if0.check_en = 1'b0;
        check(32'(if0.mismatch)); check(32'(if0.err_count)); check(32'(if0.all_ok));
        push("hold_mis", 2'b11); push("hold_err", 2);
        tick(); tick();
        check(32'(if0.mismatch)); check(32'(if0.err_count));

        // rst together with check_en while the mismatch is still present
        if0.check_en = 1'b1; rst = 1'b1;
        push("rc_mis", 0); push("rc_err", 0); push("rc_ok", 1);
        push("rc_src0", 2'b01); push("rc_src1", 0);
        tick();
        rst = 1'b0; if0.check_en = 1'b0;
        check(32'(if0.mismatch)); check(32'(if0.err_count)); check(32'(if0.all_ok));
        check(32'(if0.src_out)); check(32'(if1.src_out));

        // 2-bit counter saturates at 3 under a persistent one-slot mismatch
        lb1 = 1'b0; frc1 = 2'b01; if1.check_en = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            push("sat_err", (c > 3) ? 3 : c);
            tick();
            check(32'(if1.err_count));
        end
        if1.check_en = 1'b0;
        push("sat_mis", 2'b01); push("sat_ok", 0);
        check(32'(if1.mismatch)); check(32'(if1.all_ok));

        // Single-slot build: loopback clean, then a forced difference
        if2.value = 1'b1; if2.check_en = 1'b1;
        push("n1_src", 1);
        #1;
        check(32'(if2.src_out));
        push("n1_mis", 0); push("n1_ok", 1);
        tick();
        check(32'(if2.mismatch)); check(32'(if2.all_ok));
        lb2 = 1'b0; frc2 = 1'b0;
        push("n1_mm", 1); push("n1_err", 1); push("n1_bad", 0);
        tick();
        if2.check_en = 1'b0;
        check(32'(if2.mismatch)); check(32'(if2.err_count)); check(32'(if2.all_ok));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Bound the run in case a time control above never returns.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
